// File: rtl/prog_pulse_counter.sv
// Programmable up/down/one-shot/bounce counter with a registered terminal pulse.
// Optional enabled-cycle prescaler is built only when COUNTER_PRESCALE_EN is defined.
module prog_pulse_counter #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] period,
   input  logic             start,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic             out_pulse,
   output logic             busy,
   output logic             dir
);

   typedef enum logic [1:0] {
      M_UP      = 2'b00,
      M_DOWN    = 2'b01,
      M_ONESHOT = 2'b10,
      M_BOUNCE  = 2'b11
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("prog_pulse_counter: PRESCALE must be at least 1");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             pulse_q, pulse_d;
   mode_e            mode_q, mode_d;
   logic             mode_vld_q, mode_vld_d;
   logic             tick;
   logic             step;

   // Values the current edge starts from once a mode entry has been applied.
   state_e           eff_state;
   logic [WIDTH-1:0] eff_cnt;
   logic             eff_dir;
   mode_e            cur_mode;

   assign cur_mode = mode_e'(mode);

`ifdef COUNTER_PRESCALE_EN
   localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PSW-1:0] ps_q, ps_d;
   logic           ps_clr;

   assign tick   = (ps_q == PSW'(PRESCALE - 1));
   assign ps_clr = load | (state_q == IDLE && state_d == RUN);

   always_comb begin
      ps_d = ps_q;
      if (ps_clr)
         ps_d = '0;
      else if (en)
         ps_d = tick ? '0 : ps_q + PSW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ps_q <= '0;
      else
         ps_q <= ps_d;
   end
`else
   assign tick = 1'b1;
`endif

   assign step = en & tick;

   // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
   always_comb begin
      eff_state = state_q;
      eff_cnt   = cnt_q;
      eff_dir   = dir_q;
      // A mode is "entered" only when it differs from the last mode seen on an enabled edge.
      if (mode_vld_q && cur_mode != mode_q) begin
         if (cur_mode == M_ONESHOT) begin
            eff_state = IDLE;
            eff_cnt   = '0;
         end
         if (cur_mode == M_BOUNCE)
            eff_dir = 1'b1;
      end
      if (cur_mode != M_ONESHOT)
         eff_state = IDLE;
      if (cur_mode == M_UP || cur_mode == M_ONESHOT)
         eff_dir = 1'b1;
      else if (cur_mode == M_DOWN)
         eff_dir = 1'b0;

      state_d    = state_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      pulse_d    = 1'b0;
      mode_d     = mode_q;
      mode_vld_d = mode_vld_q;

      if (en) begin
         state_d    = eff_state;
         cnt_d      = eff_cnt;
         dir_d      = eff_dir;
         mode_d     = cur_mode;
         mode_vld_d = 1'b1;
      end

      if (load) begin
         cnt_d = (load_val > period) ? period : load_val;
      end else if (en && cur_mode == M_ONESHOT && eff_state == IDLE) begin
         if (start) begin
            state_d = RUN;
            cnt_d   = '0;
         end
      end else if (step) begin
         unique case (cur_mode)
            M_UP, M_ONESHOT: begin
               if (eff_cnt >= period) begin
                  cnt_d   = '0;
                  pulse_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = eff_cnt + WIDTH'(1);
               end
            end
            M_DOWN: begin
               if (eff_cnt > period) begin
                  cnt_d = period;
               end else if (eff_cnt == '0) begin
                  cnt_d   = period;
                  pulse_d = 1'b1;
               end else begin
                  cnt_d = eff_cnt - WIDTH'(1);
               end
            end
            M_BOUNCE: begin
               if (eff_dir) begin
                  if (eff_cnt >= period) begin
                     cnt_d   = (period == '0) ? '0 : period - WIDTH'(1);
                     dir_d   = 1'b0;
                     pulse_d = 1'b1;
                  end else begin
                     cnt_d = eff_cnt + WIDTH'(1);
                  end
               end else begin
                  if (eff_cnt == '0) begin
                     cnt_d   = (period == '0) ? '0 : WIDTH'(1);
                     dir_d   = 1'b1;
                     pulse_d = 1'b1;
                  end else begin
                     cnt_d = eff_cnt - WIDTH'(1);
                  end
               end
            end
            default: cnt_d = eff_cnt;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dir_q      <= 1'b1;
         pulse_q    <= 1'b0;
         mode_q     <= M_UP;
         mode_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         pulse_q    <= pulse_d;
         mode_q     <= mode_d;
         mode_vld_q <= mode_vld_d;
      end
   end

   assign cnt       = cnt_q;
   assign out_pulse = pulse_q;
   assign busy      = (state_q == RUN);
   assign dir       = dir_q;

endmodule

// File: tb/tb_prog_pulse_counter.sv
// Directed self-checking bench for prog_pulse_counter (default build, WIDTH=4).
module tb_prog_pulse_counter;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] period;
   logic             start;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] cnt;
   logic             out_pulse;
   logic             busy;
   logic             dir;

   int vectors     = 0;
   int miscompares = 0;

   prog_pulse_counter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .mode      (mode),
      .period    (period),
      .start     (start),
      .load      (load),
      .load_val  (load_val),
      .cnt       (cnt),
      .out_pulse (out_pulse),
      .busy      (busy),
      .dir       (dir)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input int c, input int p, input int b, input int d);
      check({tag, " cnt"}, 32'(cnt), 32'(c));
      check({tag, " pulse"}, 32'(out_pulse), 32'(p));
      if (b >= 0) check({tag, " busy"}, 32'(busy), 32'(b));
      if (d >= 0) check({tag, " dir"}, 32'(dir), 32'(d));
   endtask

   task automatic async_reset();
      reset = 1'b1;
      #1;
      check("async rst cnt", 32'(cnt), 32'd0);
      check("async rst pulse", 32'(out_pulse), 32'd0);
      check("async rst busy", 32'(busy), 32'd0);
      check("async rst dir", 32'(dir), 32'd1);
      tick();
      reset = 1'b0;
   endtask

   int up_cnt  [12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
   int up_p    [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
   int dn_cnt  [6]  = '{3, 2, 1, 0, 3, 2};
   int dn_p    [6]  = '{1, 0, 0, 0, 1, 0};
   int bo_cnt  [7]  = '{1, 2, 1, 0, 1, 2, 1};
   int bo_dir  [7]  = '{1, 1, 0, 0, 1, 1, 0};
   int bo_p    [7]  = '{0, 0, 1, 0, 1, 0, 1};
   int os_cnt  [6]  = '{1, 2, 3, 4, 5, 0};
   int os_busy [6]  = '{1, 1, 1, 1, 1, 0};
   int os_p    [6]  = '{0, 0, 0, 0, 0, 1};

   initial begin
      reset    = 1'b1;
      en       = 1'b0;
      mode     = 2'b00;
      period   = 4'd4;
      start    = 1'b0;
      load     = 1'b0;
      load_val = '0;

      tick();
      check_state("reset", 0, 0, 0, 1);
      reset = 1'b0;
      en    = 1'b1;

      // Free-run up, period 4
      for (int i = 0; i < 12; i++) begin
         tick();
         check_state($sformatf("up[%0d]", i), up_cnt[i], up_p[i], 0, 1);
      end

      // Enable low freezes count and forces the pulse low
      en = 1'b0;
      tick();
      check_state("freeze0", 2, 0, -1, 1);
      tick();
      check_state("freeze1", 2, 0, -1, 1);
      en = 1'b1;

      // Free-run down, period 3, from reset
      mode   = 2'b01;
      period = 4'd3;
      async_reset();
      for (int i = 0; i < 6; i++) begin
         tick();
         check_state($sformatf("dn[%0d]", i), dn_cnt[i], dn_p[i], 0, 0);
      end
      // Period shrinks below count: reload period without a pulse
      period = 4'd1;
      tick();
      check_state("dn shrink", 1, 0, -1, -1);
      tick();
      check_state("dn shrink+1", 0, 0, -1, -1);
      tick();
      check_state("dn shrink+2", 1, 1, -1, -1);

      // Bounce, period 2, from reset
      mode   = 2'b11;
      period = 4'd2;
      async_reset();
      for (int i = 0; i < 7; i++) begin
         tick();
         check_state($sformatf("bo[%0d]", i), bo_cnt[i], bo_p[i], -1, bo_dir[i]);
      end

      // One-shot, period 5, from reset; a start while running is ignored
      mode   = 2'b10;
      period = 4'd5;
      async_reset();
      start = 1'b1;
      tick();
      check_state("os start", 0, 0, 1, 1);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         start = (i == 2);
         tick();
         check_state($sformatf("os[%0d]", i), os_cnt[i], os_p[i], os_busy[i], 1);
      end
      start = 1'b0;
      tick();
      check_state("os idle", 0, 0, 0, 1);

      // Reset in the middle of a run acts without a clock edge
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check_state("os pre-rst", 3, 0, 1, 1);
      async_reset();

      // Load clamps to period and beats stepping, even with en low
      mode     = 2'b00;
      period   = 4'd6;
      load     = 1'b1;
      load_val = 4'd9;
      tick();
      check_state("load clamp", 6, 0, 0, 1);
      load = 1'b0;
      tick();
      check_state("wrap after load", 0, 1, 0, 1);
      load     = 1'b1;
      load_val = 4'd6;
      tick();
      check_state("load 6", 6, 0, -1, -1);
      load_val = 4'd2;
      tick();
      check_state("load on wrap", 2, 0, -1, -1);
      en       = 1'b0;
      load_val = 4'd3;
      tick();
      check_state("load en0", 3, 0, -1, -1);
      load = 1'b0;
      en   = 1'b1;

      // Entering one-shot forces idle with count 0
      mode = 2'b10;
      tick();
      check_state("enter os", 0, 0, 0, 1);

      // Period 0: free-run up pulses on every step
      mode   = 2'b00;
      period = 4'd0;
      tick();
      check_state("p0 up a", 0, 1, -1, -1);
      tick();
      check_state("p0 up b", 0, 1, -1, -1);

      // Period 0: one-shot pulses on the step after start
      mode  = 2'b10;
      start = 1'b1;
      tick();
      check_state("p0 os start", 0, 0, 1, 1);
      start = 1'b0;
      tick();
      check_state("p0 os end", 0, 1, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
